// File: rtl/dvbc_byte_to_symbol_pkg.sv
// Shared DVB-C definitions: QAM mode codes, bits-per-symbol lookup and sync byte values.
package dvbc_byte_to_symbol_pkg;

    typedef enum logic [2:0] {
        QAM16  = 3'd0,
        QAM32  = 3'd1,
        QAM64  = 3'd2,
        QAM128 = 3'd3,
        QAM256 = 3'd4
    } qam_mode_e;

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] SYNC_INV  = 8'hB8;

    function automatic logic [3:0] qam_bits(input qam_mode_e mode);
        logic [3:0] m;
        case (mode)
            QAM16:   m = 4'd4;
            QAM32:   m = 4'd5;
            QAM64:   m = 4'd6;
            QAM128:  m = 4'd7;
            QAM256:  m = 4'd8;
            default: m = 4'd4;
        endcase
        return m;
    endfunction

    // Codes 5..7 are reserved and must leave the active mode untouched.
    function automatic logic qam_mode_legal(input logic [2:0] code);
        return (code <= 3'd4);
    endfunction

endpackage

// File: rtl/dvbc_byte_to_symbol_if.sv
// Byte input / symbol output handshake bundle between interleaver, converter and QAM mapper.
interface dvbc_byte_to_symbol_if;
    import dvbc_byte_to_symbol_pkg::*;

    logic [2:0] qam_mode;
    logic [7:0] in_data;
    logic       in_sync;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_sym;
    logic       out_sync;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output qam_mode, in_data, in_sync, in_valid, out_ready,
        input  in_ready, out_sym, out_sync, out_valid
    );

    modport slave (
        input  qam_mode, in_data, in_sync, in_valid, out_ready,
        output in_ready, out_sym, out_sync, out_valid
    );

endinterface

// File: rtl/dvbc_byte_to_symbol_diff_enc.sv
// Differential coder for the two symbol MSBs (rotation-invariant QAM quadrant coding).
module dvbc_diff_enc (
    input  logic a_i,
    input  logic b_i,
    input  logic i_prev_i,
    input  logic q_prev_i,
    output logic i_o,
    output logic q_o
);
    logic d;

    assign d   = a_i ^ b_i;
    assign i_o = d ? (a_i ^ q_prev_i) : (a_i ^ i_prev_i);
    assign q_o = d ? (b_i ^ i_prev_i) : (b_i ^ q_prev_i);

endmodule

// File: rtl/dvbc_byte_to_symbol.sv
// DVB-C byte to m-tuple converter: MSB-first repacking of bytes into 4..8 bit symbols
// with differential coding of the two tuple MSBs and sync-byte tagging.
module dvbc_byte_to_symbol
    import dvbc_byte_to_symbol_pkg::*;
#(
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned INIT_MODE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dvbc_byte_to_symbol_if.slave    bus
);

    localparam int unsigned CNT_W    = $clog2(ACC_W + 1);
    localparam int unsigned FILL_MAX = ACC_W - 9;

    // Unread bits are kept left-aligned: acc_q[ACC_W-1 -: cnt_q]; everything below is zero.
    logic [ACC_W-1:0] acc_q, acc_d, acc_sh;
    logic [ACC_W-1:0] tag_q, tag_d, tag_sh;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_e;
    qam_mode_e        mode_q, mode_d;
    logic             rdy_q;
    logic [7:0]       sym_q, sym_d;
    logic             sync_q, sync_d;
    logic             vld_q, vld_d;
    logic             ip_q, ip_d;
    logic             qp_q, qp_d;

    logic [3:0]       m;
    logic [2:0]       msb_idx;
    logic [7:0]       top8;
    logic [7:0]       raw;
    logic             fire;
    logic             ext;
    logic             i_bit, q_bit;

    assign m       = qam_bits(mode_q);
    assign msb_idx = 3'(m - 4'd1);
    assign top8    = acc_q[ACC_W-1 -: 8];
    assign fire    = bus.in_valid & rdy_q;
    assign ext     = (cnt_q >= CNT_W'(m)) & (~vld_q | bus.out_ready);

    dvbc_diff_enc u_diff (
        .a_i      (top8[7]),
        .b_i      (top8[6]),
        .i_prev_i (ip_q),
        .q_prev_i (qp_q),
        .i_o      (i_bit),
        .q_o      (q_bit)
    );

    // The new byte lands directly behind whatever survives this cycle's extract.
    always_comb begin
        acc_sh = acc_q;
        tag_sh = tag_q;
        cnt_e  = cnt_q;
        if (ext) begin
            acc_sh = acc_q << m;
            tag_sh = tag_q << m;
            cnt_e  = cnt_q - CNT_W'(m);
        end

        acc_d = acc_sh;
        tag_d = tag_sh;
        cnt_d = cnt_e;
        if (fire) begin
            acc_d = acc_sh | ({bus.in_data, {(ACC_W-8){1'b0}}} >> cnt_e);
            tag_d = tag_sh | ({bus.in_sync, {(ACC_W-1){1'b0}}} >> cnt_e);
            cnt_d = cnt_e + CNT_W'(8);
        end
    end

    always_comb begin
        mode_d = mode_q;
        if ((cnt_q == '0) && !fire && qam_mode_legal(bus.qam_mode)) begin
            mode_d = qam_mode_e'(bus.qam_mode);
        end
    end

    always_comb begin
        sym_d  = sym_q;
        sync_d = sync_q;
        vld_d  = vld_q;
        ip_d   = ip_q;
        qp_d   = qp_q;
        raw    = top8 >> (4'd8 - m);
        if (bus.out_ready) begin
            vld_d = 1'b0;
        end
        if (ext) begin
            raw[msb_idx]        = i_bit;
            raw[msb_idx - 3'd1] = q_bit;
            sym_d  = raw;
            sync_d = tag_q[ACC_W-1];
            vld_d  = 1'b1;
            ip_d   = i_bit;
            qp_d   = q_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            tag_q  <= '0;
            cnt_q  <= '0;
            mode_q <= qam_mode_e'(3'(INIT_MODE));
            rdy_q  <= 1'b0;
            sym_q  <= '0;
            sync_q <= 1'b0;
            vld_q  <= 1'b0;
            ip_q   <= 1'b0;
            qp_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tag_q  <= tag_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            rdy_q  <= (cnt_d <= CNT_W'(FILL_MAX));
            sym_q  <= sym_d;
            sync_q <= sync_d;
            vld_q  <= vld_d;
            ip_q   <= ip_d;
            qp_q   <= qp_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_sym   = sym_q;
    assign bus.out_sync  = sync_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_dvbc_byte_to_symbol.sv
// Directed bench for dvbc_byte_to_symbol with a bit-level reference model feeding a symbol scoreboard.
module tb_dvbc_byte_to_symbol;

    typedef struct {
        logic [7:0] sym;
        logic       sync;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } byte_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dvbc_byte_to_symbol_if bus ();

    dvbc_byte_to_symbol #(
        .ACC_W     (24),
        .INIT_MODE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       exp_q[$];
    byte_t      pend[$];
    bit         mbits[$];
    bit         mtags[$];
    logic [7:0] rx_log[$];
    int         model_m;
    bit         m_ip, m_qp;
    int         stalls;
    bit         saw_not_ready;

    bit         hold_pend;
    logic [7:0] held_sym;
    logic       held_sync;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: serialise bytes MSB first, cut model_m-bit tuples, differentially code the MSB pair.
    function automatic void model_push(input logic [7:0] d, input logic s);
        for (int i = 7; i >= 0; i--) begin
            mbits.push_back(d[i]);
            mtags.push_back((i == 7) ? s : 1'b0);
        end
        while (mbits.size() >= model_m) begin
            logic [7:0] t;
            bit a, b, sy, iv, qv, dummy;
            a  = mbits[0];
            b  = mbits[1];
            sy = mtags[0];
            t  = '0;
            for (int k = 0; k < model_m; k++) begin
                t = {t[6:0], mbits.pop_front()};
                dummy = mtags.pop_front();
            end
            if (a ^ b) begin
                iv = a ^ m_qp;
                qv = b ^ m_ip;
            end else begin
                iv = a ^ m_ip;
                qv = b ^ m_qp;
            end
            t[model_m-1] = iv;
            t[model_m-2] = qv;
            m_ip = iv;
            m_qp = qv;
            exp_q.push_back('{sym: t, sync: sy});
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_sym", bus.out_sym, held_sym);
                check("hold_sync", bus.out_sync, held_sync);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_sym: observed %0h expected no symbol", bus.out_sym);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sym", bus.out_sym, e.sym);
                    check("sync", bus.out_sync, e.sync);
                end
                rx_log.push_back(bus.out_sym);
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            held_sym  = bus.out_sym;
            held_sync = bus.out_sync;
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic run_cycle();
        if (pend.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pend[0].d;
            bus.in_sync  = pend[0].s;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            bus.in_sync  = 1'b0;
        end
        @(negedge clk);
        if (!bus.in_ready) saw_not_ready = 1'b1;
        if (bus.in_valid && !bus.in_ready) stalls++;
        if (bus.in_valid && bus.in_ready) begin
            model_push(pend[0].d, pend[0].s);
            void'(pend.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic drain(input string tag, input int budget, output int cycles);
        cycles = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && cycles < budget) begin
            run_cycle();
            cycles++;
        end
        check(tag, pend.size() + exp_q.size(), 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic s);
        pend.push_back('{d: d, s: s});
    endtask

    task automatic do_reset(input logic [2:0] mode, input int m);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sync  = 1'b0;
        bus.qam_mode = mode;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sym", bus.out_sym, 0);
        check("rst_out_sync", bus.out_sync, 0);
        pend.delete();
        exp_q.delete();
        mbits.delete();
        mtags.delete();
        m_ip    = 1'b0;
        m_qp    = 1'b0;
        model_m = m;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, base, nz;
        logic [7:0] v;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.qam_mode  = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sync   = 1'b0;
        #1;

        // 1: 16-QAM sync-inverted byte, first-symbol latency
        do_reset(3'd0, 4);
        rx_log.delete();
        push_byte(8'hB8, 1'b1);
        run_cycle();
        check("t1_lat_n", bus.out_valid, 0);
        run_cycle();
        check("t1_lat_n1", bus.out_valid, 1);
        drain("t1_drain", 20, cyc);
        check("t1_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            check("t1_sym0", rx_log[0], 8'h0B);
            check("t1_sym1", rx_log[1], 8'h0C);
        end

        // 2: 64-QAM after reset, then a mode switch proves the count drained to zero
        do_reset(3'd2, 6);
        rx_log.delete();
        push_byte(8'hFF, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'hFF, 1'b0);
        drain("t2_drain", 30, cyc);
        check("t2_count", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            check("t2_sym0", rx_log[0], 8'h3F);
            check("t2_sym1", rx_log[1], 8'h00);
            check("t2_sym2", rx_log[2], 8'h03);
            check("t2_sym3", rx_log[3], 8'h3F);
        end
        bus.qam_mode = 3'd0;
        run_idle(2);
        model_m = 4;
        push_byte(8'hB8, 1'b1);
        drain("t2_switch_drain", 20, cyc);
        check("t2_switch_count", rx_log.size(), 6);

        // 3: 256-QAM full-rate packet of zeros
        do_reset(3'd4, 8);
        rx_log.delete();
        stalls = 0;
        for (int i = 0; i < 204; i++) push_byte(8'h00, (i == 0));
        drain("t3_drain", 260, cyc);
        check("t3_stalls", stalls, 0);
        check("t3_count", rx_log.size(), 204);
        check("t3_rate", (cyc <= 208), 1);
        nz = 0;
        foreach (rx_log[i]) if (rx_log[i] != 8'h00) nz++;
        check("t3_nonzero", nz, 0);

        // 4: 32-QAM with 10 cycles of output backpressure
        bus.qam_mode = 3'd1;
        run_idle(2);
        model_m = 5;
        base = rx_log.size();
        bus.out_ready = 1'b0;
        saw_not_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v = 8'(i * 37 + 5);
            push_byte(v, (i == 0));
        end
        run_idle(10);
        check("t4_stalled_valid", bus.out_valid, 1);
        check("t4_ready_dropped", saw_not_ready, 1);
        bus.out_ready = 1'b1;
        drain("t4_drain", 60, cyc);
        check("t4_count", rx_log.size() - base, 19);

        // 5: mode request while one residual bit is pending; reserved code afterwards
        bus.qam_mode = 3'd4;
        base = rx_log.size();
        run_idle(3);
        check("t5_no_early_sym", rx_log.size() - base, 0);
        push_byte(8'hC3, 1'b0);
        push_byte(8'h5A, 1'b0);
        push_byte(8'h99, 1'b0);
        drain("t5_drain", 30, cyc);
        check("t5_old_mode_count", rx_log.size() - base, 5);
        run_idle(2);
        model_m = 8;
        bus.qam_mode = 3'd6;
        run_idle(2);
        base = rx_log.size();
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        drain("t5_rsvd_drain", 20, cyc);
        check("t5_rsvd_count", rx_log.size() - base, 2);

        // 6: reset in the middle of a packet with a symbol held at the output
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h6D, 1'b0);
        run_idle(4);
        check("t6_pre_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        do_reset(3'd0, 4);
        rx_log.delete();
        push_byte(8'hB8, 1'b1);
        drain("t6_drain", 20, cyc);
        check("t6_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            check("t6_sym0", rx_log[0], 8'h0B);
            check("t6_sym1", rx_log[1], 8'h0C);
        end
        run_idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
